reg_status_commit: RTL and testbench

- Sits between the ROB commit port and the register file write port; also serves the issue stage's dependency lookups.
- Tracks, per architectural register, whether a producing instruction is in flight and which ROB tag owns it.
- On commit, drives the register file write port one cycle later and releases the register's busy status.
- On flush, clears all speculative busy status.

---
 rtl/reg_status_commit_if.sv | 56 +++++
 rtl/reg_status_commit.sv | 125 ++++++++++++
 tb/tb_reg_status_commit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_status_commit_if.sv
// Bundle between the issue stage / ROB and the register-status tracker.
// Carries global ready/flush, issue, dependency lookups, commit and the
// register-file write port.
interface reg_status_commit_if #(
    parameter int unsigned ROB_TAG_W = 3
);
    logic                 rdy_in;
    logic                 flush_pipline;

    logic                 issue_valid;
    logic [4:0]           issue_rd_id;
    logic [ROB_TAG_W-1:0] issue_rob_tag;

    logic [4:0]           rs1_query_id;
    logic                 rs1_busy;
    logic [ROB_TAG_W-1:0] rs1_tag;
    logic [4:0]           rs2_query_id;
    logic                 rs2_busy;
    logic [ROB_TAG_W-1:0] rs2_tag;

    logic                 rs1_fwd_valid;
    logic                 rs2_fwd_valid;
    logic [31:0]          rs1_fwd_val;
    logic [31:0]          rs2_fwd_val;

    logic                 commit_valid;
    logic [4:0]           commit_rd_id;
    logic [ROB_TAG_W-1:0] commit_rob_tag;
    logic [31:0]          commit_val;

    logic                 is_writing_rd;
    logic [4:0]           rd_reg_id;
    logic [31:0]          rd_val;

    // Pipeline side: drives issue/lookup/commit, observes status and writes.
    modport master (
        output rdy_in, flush_pipline,
        output issue_valid, issue_rd_id, issue_rob_tag,
        output rs1_query_id, rs2_query_id,
        input  rs1_busy, rs1_tag, rs2_busy, rs2_tag,
        input  rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_val, rs2_fwd_val,
        output commit_valid, commit_rd_id, commit_rob_tag, commit_val,
        input  is_writing_rd, rd_reg_id, rd_val
    );

    // Tracker side.
    modport slave (
        input  rdy_in, flush_pipline,
        input  issue_valid, issue_rd_id, issue_rob_tag,
        input  rs1_query_id, rs2_query_id,
        output rs1_busy, rs1_tag, rs2_busy, rs2_tag,
        output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_val, rs2_fwd_val,
        input  commit_valid, commit_rd_id, commit_rob_tag, commit_val,
        output is_writing_rd, rd_reg_id, rd_val
    );
endinterface

// File: rtl/reg_status_commit.sv
// Register status table with commit write port.
// Tracks per architectural register whether an in-flight producer exists and
// its ROB tag, answers two issue-stage lookups, and turns ROB commits into a
// register-file write one cycle later.
// Optional macro REG_STATUS_FWD_EN: same-cycle forwarding of the committing
// value and of the value currently on the register-file write port.
module reg_status_commit #(
    parameter int unsigned ROB_TAG_W = 3
) (
    input logic               clk_in,
    input logic               rst_n_in,
    reg_status_commit_if.slave bus
);
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_ID_W = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_QRY  = 2;

    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [ROB_TAG_W-1:0] tag_q [NUM_REGS];
    logic [ROB_TAG_W-1:0] tag_d [NUM_REGS];

    logic                 wr_q, wr_d;
    logic [REG_ID_W-1:0]  wr_id_q, wr_id_d;
    logic [DATA_W-1:0]    wr_val_q, wr_val_d;

    logic                 commit_owner_c;

    logic [REG_ID_W-1:0]  qry_id   [NUM_QRY];
    logic [NUM_QRY-1:0]   qry_busy;
    logic [ROB_TAG_W-1:0] qry_tag  [NUM_QRY];
    logic [NUM_QRY-1:0]   qry_fwd;
    logic [DATA_W-1:0]    qry_fval [NUM_QRY];

    // Commit releases the register only if it is still the registered owner.
    assign commit_owner_c = bus.commit_valid
                         && (bus.commit_rd_id != '0)
                         && busy_q[bus.commit_rd_id]
                         && (tag_q[bus.commit_rd_id] == bus.commit_rob_tag);

    // Next-state: flush beats issue, issue beats a same-register release.
    always_comb begin
        busy_d   = busy_q;
        tag_d    = tag_q;
        wr_d     = wr_q;
        wr_id_d  = wr_id_q;
        wr_val_d = wr_val_q;
        if (bus.rdy_in) begin
            wr_d = 1'b0;
            if (bus.commit_valid && (bus.commit_rd_id != '0)) begin
                wr_d     = 1'b1;
                wr_id_d  = bus.commit_rd_id;
                wr_val_d = bus.commit_val;
            end
            if (bus.flush_pipline) begin
                busy_d = '0;
            end else begin
                if (commit_owner_c) begin
                    busy_d[bus.commit_rd_id] = 1'b0;
                end
                if (bus.issue_valid && (bus.issue_rd_id != '0)) begin
                    busy_d[bus.issue_rd_id] = 1'b1;
                    tag_d[bus.issue_rd_id]  = bus.issue_rob_tag;
                end
            end
        end
    end

    // State and write-port registers; reset drops any pending write.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q   <= '0;
            tag_q    <= '{default: '0};
            wr_q     <= 1'b0;
            wr_id_q  <= '0;
            wr_val_q <= '0;
        end else begin
            busy_q   <= busy_d;
            tag_q    <= tag_d;
            wr_q     <= wr_d;
            wr_id_q  <= wr_id_d;
            wr_val_q <= wr_val_d;
        end
    end

    assign qry_id[0] = bus.rs1_query_id;
    assign qry_id[1] = bus.rs2_query_id;

    // Dependency lookups from current state; x0 is never busy.
    always_comb begin
        qry_busy = '0;
        qry_tag  = '{default: '0};
        qry_fwd  = '0;
        qry_fval = '{default: '0};
        for (int p = 0; p < int'(NUM_QRY); p++) begin
            if (qry_id[p] != '0) begin
                qry_busy[p] = busy_q[qry_id[p]];
                qry_tag[p]  = tag_q[qry_id[p]];
`ifdef REG_STATUS_FWD_EN
                if (bus.rdy_in && commit_owner_c && (bus.commit_rd_id == qry_id[p])) begin
                    qry_fwd[p]  = 1'b1;
                    qry_fval[p] = bus.commit_val;
                    qry_busy[p] = 1'b0;
                end else if (wr_q && (wr_id_q == qry_id[p])) begin
                    qry_fwd[p]  = 1'b1;
                    qry_fval[p] = wr_val_q;
                end
`endif
            end
        end
    end

    assign bus.rs1_busy      = qry_busy[0];
    assign bus.rs1_tag       = qry_tag[0];
    assign bus.rs2_busy      = qry_busy[1];
    assign bus.rs2_tag       = qry_tag[1];
    assign bus.rs1_fwd_valid = qry_fwd[0];
    assign bus.rs1_fwd_val   = qry_fval[0];
    assign bus.rs2_fwd_valid = qry_fwd[1];
    assign bus.rs2_fwd_val   = qry_fval[1];

    assign bus.is_writing_rd = wr_q;
    assign bus.rd_reg_id     = wr_id_q;
    assign bus.rd_val        = wr_val_q;
endmodule

// File: tb/tb_reg_status_commit.sv
// Bench for reg_status_commit: directed scenarios followed by random traffic,
// all compared each cycle against a register-level reference model.
module tb_reg_status_commit;
    localparam int unsigned TW = 3;

    logic clk;
    logic rst_n;

    reg_status_commit_if #(.ROB_TAG_W(TW)) bus ();

    reg_status_commit #(.ROB_TAG_W(TW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural busy/owner table plus write port.
    bit          m_busy [32];
    logic [TW-1:0] m_tag [32];
    bit          m_wr;
    logic [4:0]  m_id;
    logic [31:0] m_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        m_wr  = 1'b0;
        m_id  = '0;
        m_val = '0;
    endtask

    task automatic idle();
        bus.rdy_in         = 1'b1;
        bus.flush_pipline  = 1'b0;
        bus.issue_valid    = 1'b0;
        bus.issue_rd_id    = '0;
        bus.issue_rob_tag  = '0;
        bus.commit_valid   = 1'b0;
        bus.commit_rd_id   = '0;
        bus.commit_rob_tag = '0;
        bus.commit_val     = '0;
    endtask

    // Expected lookup result for one query register under current inputs.
    task automatic expect_query(input logic [4:0] q, output logic eb, output logic [TW-1:0] et,
                                output logic ef, output logic [31:0] ev);
        eb = (q != 0) ? m_busy[q] : 1'b0;
        et = (q != 0) ? m_tag[q] : '0;
        ef = 1'b0;
        ev = '0;
`ifdef REG_STATUS_FWD_EN
        if (q != 0) begin
            if (bus.rdy_in && bus.commit_valid && bus.commit_rd_id == q && m_busy[q]
                && m_tag[q] == bus.commit_rob_tag) begin
                ef = 1'b1; ev = bus.commit_val; eb = 1'b0;
            end else if (m_wr && m_id == q) begin
                ef = 1'b1; ev = m_val;
            end
        end
`endif
    endtask

    task automatic check_all();
        logic eb; logic [TW-1:0] et; logic ef; logic [31:0] ev;
        expect_query(bus.rs1_query_id, eb, et, ef, ev);
        check("rs1_busy", 32'(bus.rs1_busy), 32'(eb));
        check("rs1_tag", 32'(bus.rs1_tag), 32'(et));
        check("rs1_fwd_valid", 32'(bus.rs1_fwd_valid), 32'(ef));
        if (ef) check("rs1_fwd_val", bus.rs1_fwd_val, ev);
        expect_query(bus.rs2_query_id, eb, et, ef, ev);
        check("rs2_busy", 32'(bus.rs2_busy), 32'(eb));
        check("rs2_tag", 32'(bus.rs2_tag), 32'(et));
        check("rs2_fwd_valid", 32'(bus.rs2_fwd_valid), 32'(ef));
        if (ef) check("rs2_fwd_val", bus.rs2_fwd_val, ev);
        check("is_writing_rd", 32'(bus.is_writing_rd), 32'(m_wr));
        if (m_wr) begin
            check("rd_reg_id", 32'(bus.rd_reg_id), 32'(m_id));
            check("rd_val", bus.rd_val, m_val);
        end
    endtask

    // Apply the architectural rules for one accepted cycle.
    task automatic model_update();
        logic [4:0] c;
        if (!bus.rdy_in) return;
        c = bus.commit_rd_id;
        m_wr = bus.commit_valid && (c != 0);
        if (m_wr) begin
            m_id  = c;
            m_val = bus.commit_val;
        end
        if (bus.flush_pipline) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (bus.commit_valid && c != 0 && m_busy[c] && m_tag[c] == bus.commit_rob_tag)
                m_busy[c] = 1'b0;
            if (bus.issue_valid && bus.issue_rd_id != 0) begin
                m_busy[bus.issue_rd_id] = 1'b1;
                m_tag[bus.issue_rd_id]  = bus.issue_rob_tag;
            end
        end
    endtask

    // One clock: check mid-cycle, advance model, land just after the edge.
    task automatic step();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [TW-1:0] t);
        bus.issue_valid = 1'b1; bus.issue_rd_id = rd; bus.issue_rob_tag = t;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [TW-1:0] t, input logic [31:0] v);
        bus.commit_valid = 1'b1; bus.commit_rd_id = rd; bus.commit_rob_tag = t; bus.commit_val = v;
    endtask

    initial begin
        idle();
        bus.rs1_query_id = '0;
        bus.rs2_query_id = '0;
        model_reset();
        rst_n = 1'b0;
        #12;
        bus.rs1_query_id = 5'd5;
        #1;
        check("reset_busy_x5", 32'(bus.rs1_busy), 32'd0);
        check("reset_tag_x5", 32'(bus.rs1_tag), 32'd0);
        check("reset_wr", 32'(bus.is_writing_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Issue then commit x5.
        issue(5, 3); step();
        idle(); bus.rs1_query_id = 5; #1;
        check("x5_busy_after_issue", 32'(bus.rs1_busy), 32'd1);
        check("x5_tag_after_issue", 32'(bus.rs1_tag), 32'd3);
        commit(5, 3, 32'hDEADBEEF); step();
        idle(); #1;
        check("x5_wr", 32'(bus.is_writing_rd), 32'd1);
        check("x5_wr_id", 32'(bus.rd_reg_id), 32'd5);
        check("x5_wr_val", bus.rd_val, 32'hDEADBEEF);
        check("x5_released", 32'(bus.rs1_busy), 32'd0);
        step();

        // Older commit must not release a younger owner.
        issue(7, 1); step();
        idle(); issue(7, 4); step();
        idle(); commit(7, 1, 32'h0000_0707); bus.rs1_query_id = 7; step();
        idle(); #1;
        check("x7_still_busy", 32'(bus.rs1_busy), 32'd1);
        check("x7_young_tag", 32'(bus.rs1_tag), 32'd4);
        check("x7_wr_id", 32'(bus.rd_reg_id), 32'd7);
        check("x7_wr", 32'(bus.is_writing_rd), 32'd1);
        step();

        // Same-cycle issue and commit to x9: issue wins.
        issue(9, 6); step();
        idle(); issue(9, 2); commit(9, 6, 32'h99); bus.rs2_query_id = 9; step();
        idle(); #1;
        check("x9_busy", 32'(bus.rs2_busy), 32'd1);
        check("x9_tag", 32'(bus.rs2_tag), 32'd2);
        check("x9_wr_id", 32'(bus.rd_reg_id), 32'd9);
        step();

        // Flush with concurrent commit and ignored issue.
        issue(3, 0); step();
        idle(); issue(4, 1); step();
        idle(); bus.flush_pipline = 1'b1; commit(4, 1, 32'h12); issue(10, 5);
        bus.rs1_query_id = 3; bus.rs2_query_id = 4; #1;
        check("flush_cycle_preflush_x3", 32'(bus.rs1_busy), 32'd1);
        step();
        idle(); #1;
        check("flush_x3", 32'(bus.rs1_busy), 32'd0);
        check("flush_x4", 32'(bus.rs2_busy), 32'd0);
        check("flush_wr_id", 32'(bus.rd_reg_id), 32'd4);
        check("flush_wr_val", bus.rd_val, 32'h12);
        bus.rs1_query_id = 10; #1;
        check("flush_issue_ignored", 32'(bus.rs1_busy), 32'd0);
        step();

        // rdy_in low holds everything, commit not accepted.
        issue(11, 2); commit(4, 3, 32'h77); step();
        idle(); bus.rdy_in = 1'b0; commit(11, 2, 32'hAB); issue(12, 1);
        bus.rs1_query_id = 11; bus.rs2_query_id = 12; step();
        idle(); #1;
        check("stall_x11_busy", 32'(bus.rs1_busy), 32'd1);
        check("stall_x12_idle", 32'(bus.rs2_busy), 32'd0);
        check("stall_wr_held", 32'(bus.is_writing_rd), 32'd1);
        check("stall_val_held", bus.rd_val, 32'h77);
        step();

        // Commit to x0 produces no write.
        commit(0, 0, 32'h5555); step();
        idle(); #1;
        check("x0_no_write", 32'(bus.is_writing_rd), 32'd0);
        step();

`ifdef REG_STATUS_FWD_EN
        issue(6, 5); step();
        idle(); commit(6, 5, 32'h55); bus.rs1_query_id = 6; #1;
        check("fwd_a_valid", 32'(bus.rs1_fwd_valid), 32'd1);
        check("fwd_a_val", bus.rs1_fwd_val, 32'h55);
        check("fwd_a_busy", 32'(bus.rs1_busy), 32'd0);
        step();
        idle(); #1;
        check("fwd_b_valid", 32'(bus.rs1_fwd_valid), 32'd1);
        check("fwd_b_val", bus.rs1_fwd_val, 32'h55);
        step();
`endif

        // Reset in the middle of a commit drops the write.
        issue(13, 3); step();
        idle(); commit(13, 3, 32'hCAFE);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_busy", 32'(bus.rs1_busy), 32'd0);
        @(posedge clk);
        #1;
        check("rst_drop_write", 32'(bus.is_writing_rd), 32'd0);
        rst_n = 1'b1;
        idle();
        step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r;
            idle();
            bus.rdy_in        = ($urandom_range(99) < 85);
            bus.flush_pipline = ($urandom_range(99) < 4);
            if ($urandom_range(1) == 1) issue(5'($urandom_range(31)), TW'($urandom));
            if ($urandom_range(1) == 1) begin
                r = 5'($urandom_range(31));
                commit(r, ($urandom_range(2) != 0) ? m_tag[r] : TW'($urandom), $urandom);
            end
            bus.rs1_query_id = ($urandom_range(1) == 1) ? bus.commit_rd_id : 5'($urandom);
            bus.rs2_query_id = ($urandom_range(1) == 1) ? bus.issue_rd_id : 5'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
